// File: rtl/udp_pixel_wr_sched.sv
// Buffers parsed UDP RGB pixels with linear raster addresses and issues them
// to the frame-buffer writer over a req/ack handshake.
module udp_pixel_wr_sched #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 19
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_pix_valid,
  input  logic [7:0]        i_channel_B,
  input  logic [7:0]        i_channel_G,
  input  logic [7:0]        i_channel_R,
  input  logic              i_frame_sync,
  output logic              o_wr_req,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [23:0]       o_wr_data,
  input  logic              i_wr_ack,
  output logic              o_frame_done,
  output logic              o_overflow,
  output logic              o_busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int ENT_W = ADDR_W + 24;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);
  localparam logic [PTR_W:0]    FULL_CNT  = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic {S_IDLE, S_REQ} state_t;

  state_t            state, state_next;
  logic [ENT_W-1:0]  mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [PTR_W:0]    count;
  logic [ADDR_W-1:0] addr_cnt, pix_addr;
  logic              fifo_empty, pop, push, frame_wrap;

  assign fifo_empty = (count == '0);
  assign pix_addr   = i_frame_sync ? '0 : addr_cnt;
  assign frame_wrap = i_pix_valid && !i_frame_sync && (addr_cnt == LAST_ADDR);
  // A full FIFO can still take a pixel if the head leaves on the same edge.
  assign push       = i_pix_valid && ((count < FULL_CNT) || pop);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= S_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          state_next = S_REQ;
        end
      end
      S_REQ: begin
        if (i_wr_ack) begin
          if (!fifo_empty) pop = 1'b1;
          else             state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= {pix_addr, i_channel_B, i_channel_G, i_channel_R};
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_wr_addr <= '0;
      o_wr_data <= '0;
    end else if (pop) begin
      {o_wr_addr, o_wr_data} <= mem[rd_ptr];
    end
  end

  // Dropped pixels still consume an address so the raster stays aligned.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      addr_cnt     <= '0;
      o_frame_done <= 1'b0;
      o_overflow   <= 1'b0;
    end else begin
      o_frame_done <= frame_wrap;
      if (i_frame_sync)
        addr_cnt <= i_pix_valid ? ADDR_W'(1) : '0;
      else if (i_pix_valid)
        addr_cnt <= (addr_cnt == LAST_ADDR) ? '0 : addr_cnt + ADDR_W'(1);
      if (i_pix_valid && !push) o_overflow <= 1'b1;
      else if (i_frame_sync)    o_overflow <= 1'b0;
    end
  end

  assign o_wr_req = (state == S_REQ);
  assign o_busy   = !fifo_empty || o_wr_req;

endmodule

// File: tb/tb_udp_pixel_wr_sched.sv
// Randomized and directed bench for udp_pixel_wr_sched, checked every cycle
// against a queue-based model of the capture/write pipeline.
module tb_udp_pixel_wr_sched;

  localparam int H    = 4;
  localparam int V    = 2;
  localparam int D    = 4;
  localparam int AW   = 19;
  localparam int LAST = H * V - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pix_valid = 1'b0;
  logic          frame_sync = 1'b0;
  logic          wr_ack = 1'b0;
  logic [7:0]    b = '0, g = '0, r = '0;
  logic          wr_req, frame_done, overflow, busy;
  logic [AW-1:0] wr_addr;
  logic [23:0]   wr_data;

  int total = 0;
  int bad = 0;
  int writes_seen = 0;
  int fd_seen = 0;

  logic [AW+23:0] m_fifo[$];
  logic           m_hold_v;
  logic [AW+23:0] m_hold;
  int             m_addr;
  logic           m_ovf, m_fd;

  udp_pixel_wr_sched #(.H_ACTIVE(H), .V_ACTIVE(V), .FIFO_DEPTH(D), .ADDR_W(AW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_pix_valid(pix_valid),
    .i_channel_B(b), .i_channel_G(g), .i_channel_R(r), .i_frame_sync(frame_sync),
    .o_wr_req(wr_req), .o_wr_addr(wr_addr), .o_wr_data(wr_data), .i_wr_ack(wr_ack),
    .o_frame_done(frame_done), .o_overflow(overflow), .o_busy(busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_fifo.delete();
    m_hold_v = 1'b0;
    m_hold   = '0;
    m_addr   = 0;
    m_ovf    = 1'b0;
    m_fd     = 1'b0;
  endtask

  // One clock edge of the reference: head leaves first, then the new pixel joins.
  task automatic model_edge();
    int   sz;
    int   paddr;
    logic pop, push_ok;
    sz      = m_fifo.size();
    pop     = (sz > 0) && (!m_hold_v || wr_ack);
    push_ok = pix_valid && ((sz < D) || pop);
    paddr   = frame_sync ? 0 : m_addr;
    m_fd    = pix_valid && !frame_sync && (m_addr == LAST);
    if (pix_valid && !push_ok) m_ovf = 1'b1;
    else if (frame_sync)       m_ovf = 1'b0;
    if (pop) begin
      m_hold   = m_fifo.pop_front();
      m_hold_v = 1'b1;
    end else if (m_hold_v && wr_ack) begin
      m_hold_v = 1'b0;
    end
    if (push_ok) m_fifo.push_back({AW'(paddr), b, g, r});
    if (frame_sync)     m_addr = pix_valid ? 1 : 0;
    else if (pix_valid) m_addr = (m_addr == LAST) ? 0 : m_addr + 1;
  endtask

  task automatic check_all();
    checkOutput("wr_req", 64'(wr_req), 64'(m_hold_v));
    if (m_hold_v) begin
      checkOutput("wr_addr", 64'(wr_addr), 64'(m_hold[AW+23:24]));
      checkOutput("wr_data", 64'(wr_data), 64'(m_hold[23:0]));
    end
    checkOutput("busy", 64'(busy), 64'((m_fifo.size() > 0) || m_hold_v));
    checkOutput("overflow", 64'(overflow), 64'(m_ovf));
    checkOutput("frame_done", 64'(frame_done), 64'(m_fd));
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic applyStimulus(input logic v, input logic [7:0] bb, input logic [7:0] gg,
                               input logic [7:0] rr, input logic s, input logic a);
    pix_valid  = v;
    b = bb; g = gg; r = rr;
    frame_sync = s;
    wr_ack     = a;
    if (wr_req && a) writes_seen++;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    if (frame_done) fd_seen++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    pix_valid = 1'b0; frame_sync = 1'b0; wr_ack = 1'b0;
    #1;
    checkOutput("rst_wr_req", 64'(wr_req), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_overflow", 64'(overflow), 64'd0);
    checkOutput("rst_frame_done", 64'(frame_done), 64'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    writes_seen = 0;
    fd_seen = 0;
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    do_reset();

    // Three pixels streamed with ack held high.
    applyStimulus(1, 8'h01, 8'h02, 8'h03, 0, 1);
    applyStimulus(1, 8'h04, 8'h05, 8'h06, 0, 1);
    applyStimulus(1, 8'h07, 8'h08, 8'h09, 0, 1);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("t1_writes", 64'(writes_seen), 64'd3);
    checkOutput("t1_busy_after", 64'(busy), 64'd0);

    // Ack withheld: six pixels, the sixth overflows.
    do_reset();
    for (int i = 0; i < 6; i++) applyStimulus(1, 8'(i), 8'(i + 16), 8'(i + 32), 0, 0);
    checkOutput("t2_overflow", 64'(overflow), 64'd1);
    for (int i = 0; i < 8; i++) applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("t2_writes", 64'(writes_seen), 64'd5);

    // Move the address counter to 5, then sync with a coincident pixel.
    for (int i = 0; i < 7; i++) applyStimulus(1, 8'(i + 48), 8'h11, 8'h22, 0, 1);
    applyStimulus(1, 8'hAA, 8'hBB, 8'hCC, 1, 1);
    checkOutput("t4_overflow_cleared", 64'(overflow), 64'd0);
    applyStimulus(1, 8'hDD, 8'hEE, 8'hFF, 0, 1);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 0, 1);

    // Whole frame of 8 pixels plus one: exactly one frame_done.
    do_reset();
    for (int i = 0; i < 9; i++) applyStimulus(1, 8'(i), 8'(2 * i), 8'(3 * i), 0, 1);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("t3_frame_done_count", 64'(fd_seen), 64'd1);

    // Ack every fourth cycle while requests are pending.
    do_reset();
    for (int i = 0; i < 3; i++) applyStimulus(1, 8'(i + 96), 8'h5A, 8'hA5, 0, 0);
    for (int i = 0; i < 16; i++) applyStimulus(0, 0, 0, 0, 0, (i % 4) == 3);
    checkOutput("t5_writes", 64'(writes_seen), 64'd3);

    // Reset while a request is pending with two entries queued.
    do_reset();
    for (int i = 0; i < 3; i++) applyStimulus(1, 8'(i + 200), 8'h01, 8'h02, 0, 0);
    checkOutput("t6_req_before", 64'(wr_req), 64'd1);
    do_reset();
    for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("t6_no_stale", 64'(writes_seen), 64'd0);

    // Random traffic.
    do_reset();
    for (int i = 0; i < 500; i++)
      applyStimulus($urandom_range(0, 1) == 1, 8'($urandom), 8'($urandom), 8'($urandom),
                    $urandom_range(0, 29) == 0, $urandom_range(0, 2) != 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
